// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } arb_state_t;

  localparam int UART_DW          = 8;
  localparam int LOCK_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotate-priority encoder: first set bit of validMask searching from ptr+1
// upwards, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  validMask,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  int cand;

  // Walk from the farthest candidate to the nearest so the nearest hit is
  // the one left standing, with no early exit from the loop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int off = N; off >= 1; off--) begin
      cand = (int'(ptr) + off) % N;
      if (validMask[cand]) begin
        hit = 1'b1;
        idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ requesters, with
// packet lock and lock timeout. UART_TX_ARBITER_STATS_EN adds byte counters.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*UART_DW-1:0] req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       tx_start,
  output logic [UART_DW-1:0]         tx_data,
  input  logic                       tx_busy,
  output logic [IDW-1:0]             grant_id,
  output logic                       locked,
  output logic                       arb_busy
`ifdef UART_TX_ARBITER_STATS_EN
  ,
  input  logic                       stat_clr,
  output logic [NUM_REQ*16-1:0]      stat_bytes
`endif
);

  localparam int            TW     = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam bit            TO_EN  = (LOCK_TIMEOUT > 0);
  localparam logic [TW-1:0] TO_END = TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  arb_state_t           state, stateNext;
  logic [IDW-1:0]       rrPtr, owner, pickIdx;
  logic [NUM_REQ-1:0]   eligible;
  logic                 pickHit, accept, ownerIdle, timeoutHit;
  logic [TW-1:0]        idleCnt;

  // While locked only the owner may compete; everyone else is held off.
  assign eligible = locked ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .validMask (eligible),
    .ptr       (rrPtr),
    .hit       (pickHit),
    .idx       (pickIdx)
  );

  // Gated by rst_n so no strobe leaks out while reset is held.
  assign accept     = rst_n && (state == IDLE) && pickHit && !tx_busy;
  assign req_ready  = accept ? (NUM_REQ'(1) << pickIdx) : '0;
  assign ownerIdle  = TO_EN && (state == IDLE) && locked && !req_valid[owner];
  assign timeoutHit = ownerIdle && (idleCnt == TO_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rrPtr    <= IDW'(NUM_REQ - 1);
      owner    <= '0;
      locked   <= 1'b0;
      idleCnt  <= '0;
      tx_data  <= '0;
      grant_id <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      state <= stateNext;
      if (accept) begin
        tx_data  <= req_data[pickIdx*UART_DW +: UART_DW];
        grant_id <= pickIdx;
        idleCnt  <= '0;
        if (req_last[pickIdx]) begin
          locked <= 1'b0;
          rrPtr  <= pickIdx;
        end else begin
          locked <= 1'b1;
          owner  <= pickIdx;
        end
      end else if (timeoutHit) begin
        locked  <= 1'b0;
        rrPtr   <= owner;
        idleCnt <= '0;
      end else if (ownerIdle) begin
        idleCnt <= idleCnt + 1'b1;
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:      if (accept)   stateNext = LOAD;
      LOAD:                    stateNext = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy)  stateNext = WAIT_DONE;
      WAIT_DONE: if (!tx_busy) stateNext = IDLE;
      default:                 stateNext = IDLE;
    endcase
  end

  assign tx_start = (state == LOAD);
  assign arb_busy = (state != IDLE);

`ifdef UART_TX_ARBITER_STATS_EN
  logic [15:0] statCnt [NUM_REQ];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is a handful of flops, not a RAM, so it can and
      // must be reset element by element.
      for (int i = 0; i < NUM_REQ; i++) statCnt[i] <= '0;
    end else if (stat_clr) begin
      for (int i = 0; i < NUM_REQ; i++) statCnt[i] <= '0;
    end else if (accept && (statCnt[pickIdx] != 16'hFFFF)) begin
      statCnt[pickIdx] <= statCnt[pickIdx] + 16'd1;
    end
  end

  always_comb begin
    stat_bytes = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_bytes[16*i +: 16] = statCnt[i];
  end
`endif

endmodule
